// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-RAM write and status bundle for imem_loader.
// slave = loader side, master = host/testbench side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;

  modport slave (
    input  start,
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output cpu_hold,
    output busy,
    output done,
    output error,
    output err_code
  );

  modport master (
    output start,
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  cpu_hold,
    input  busy,
    input  done,
    input  error,
    input  err_code
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction RAM loader: length header, LE word assembly, sequential
// writes from address 0, trailing XOR checksum, CPU hold while loading.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  imem_loader_if.slave bus
);

  localparam int CW = ADDR_W + 1;
  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        ecode_q, ecode_d;

  logic              ready;
  logic              active;
  logic              xfer;
  logic [15:0]       n_new;
  logic [CW-1:0]     idx_nx;
  logic [31:0]       asm_word;

  assign xfer   = bus.byte_valid & ready;
  assign n_new  = {bus.byte_data, len_q[7:0]};
  assign idx_nx = idx_q + 1'b1;

  always_comb begin
    asm_word = word_q;
    asm_word[8*lane_q +: 8] = bus.byte_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      ecode_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      error_q <= error_d;
      ecode_q <= ecode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    word_d  = word_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    error_d = error_q;
    ecode_d = ecode_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d = S_LEN_LO;
          done_d  = 1'b0;
          error_d = 1'b0;
          ecode_d = 2'b00;
          csum_d  = '0;
          lane_d  = '0;
          idx_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d   = {8'h00, bus.byte_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = n_new;
          if ({1'b0, n_new} > MAX_N) begin
            state_d = S_ERR;
            error_d = 1'b1;
            ecode_d = 2'b01;
          end else if (n_new == 16'h0000) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ bus.byte_data;
          word_d = asm_word;
          lane_d = lane_q + 2'd1;
          // 4th lane: register the write so it lands one cycle later
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = asm_word;
            addr_d  = idx_q[ADDR_W-1:0];
            idx_d   = idx_nx;
            if (16'(idx_nx) == len_q) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (bus.byte_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
            ecode_d = 2'b10;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    active = 1'b0;
    unique case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: active = 1'b1;
      default:                             active = 1'b0;
    endcase
    ready = active;
  end

  assign bus.byte_ready = ready;
  assign bus.busy       = active;
  assign bus.cpu_hold   = active;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.err_code   = ecode_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: driver pushes expected RAM writes,
// a negedge monitor pops and checks address, data and write cycle.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          due;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  logic [7:0] xsum;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, output int c);
    int n;
    n = 0;
    c = -1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (c < 0 && n < 100) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) c = cyc;
      n++;
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b0;
    chk("byte_accepted", 32'(c >= 0), 32'd1);
  endtask

  task automatic send_b(input logic [7:0] b);
    int c;
    send(b, c);
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [31:0] w,
                           input int gap);
    int c;
    exp_t e;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      send(b, c);
      xsum = xsum ^ b;
      if (i == 3) begin
        e.due  = c + 1;
        e.addr = addr;
        e.data = w;
        sbq.push_back(e);
      end
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_start;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic status(input string nm, input logic d, input logic e,
                        input logic [1:0] ec, input logic bz);
    chk({nm, ".done"}, 32'(bus.done), 32'(d));
    chk({nm, ".error"}, 32'(bus.error), 32'(e));
    chk({nm, ".err_code"}, 32'(bus.err_code), 32'(ec));
    chk({nm, ".busy"}, 32'(bus.busy), 32'(bz));
    chk({nm, ".cpu_hold"}, 32'(bus.cpu_hold), 32'(bz));
    chk({nm, ".byte_ready"}, 32'(bus.byte_ready), 32'(bz));
  endtask

  task automatic all_zero(input string nm);
    status(nm, 1'b0, 1'b0, 2'b00, 1'b0);
    chk({nm, ".mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({nm, ".mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({nm, ".mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  task automatic run_normal(input logic [7:0] cs);
    pulse_start();
    chk("start.busy_rise", 32'(bus.busy), 32'd1);
    chk("start.hold_rise", 32'(bus.cpu_hold), 32'd1);
    send_b(8'h02);
    send_b(8'h00);
    xsum = 8'h00;
    send_word(8'd0, 32'h0000_0013, 0);
    send_word(8'd1, 32'h0010_0093, 0);
    send_b(cs);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL write_missing: no mem_we at cycle %0d, want addr %h data %h",
                 e.due, e.addr, e.data);
      end
      if (bus.mem_we === 1'b1) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL write_unexpected: got addr %h data %h, want no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e = sbq.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
          chk("wr_data", bus.mem_wdata, e.data);
          chk("wr_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] ib;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    xsum           = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_normal(8'h90);
    status("normal", 1'b1, 1'b0, 2'b00, 1'b0);

    run_normal(8'h91);
    status("csum_bad", 1'b0, 1'b1, 2'b10, 1'b0);

    pulse_start();
    send_b(8'h01);
    send_b(8'h01);
    status("len_257", 1'b0, 1'b1, 2'b01, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    pulse_start();
    send_b(8'h00);
    send_b(8'h01);
    status("len_256_hdr", 1'b0, 1'b0, 2'b00, 1'b1);
    xsum = 8'h00;
    for (int i = 0; i < 256; i++) begin
      ib = i[7:0];
      send_word(ib, {ib, 8'hA5, ~ib, 8'h3C}, 0);
    end
    send_b(xsum);
    status("len_256", 1'b1, 1'b0, 2'b00, 1'b0);

    pulse_start();
    send_b(8'h00);
    send_b(8'h00);
    send_b(8'h00);
    status("len_0_ok", 1'b1, 1'b0, 2'b00, 1'b0);

    pulse_start();
    send_b(8'h00);
    send_b(8'h00);
    send_b(8'h05);
    status("len_0_bad", 1'b0, 1'b1, 2'b10, 1'b0);

    pulse_start();
    send_b(8'h02);
    send_b(8'h00);
    xsum = 8'h00;
    send_word(8'd0, 32'h0000_0013, 2);
    pulse_start();
    chk("busy_start.busy", 32'(bus.busy), 32'd1);
    send_word(8'd1, 32'h0010_0093, 2);
    send_b(8'h90);
    status("gaps", 1'b1, 1'b0, 2'b00, 1'b0);

    pulse_start();
    send_b(8'h02);
    send_b(8'h00);
    xsum = 8'h00;
    send_word(8'd0, 32'h0000_0013, 0);
    send_b(8'h93);
    send_b(8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_normal(8'h90);
    status("after_rst", 1'b1, 1'b0, 2'b00, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
